// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the CPU run sequencer
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_RST,
    S_RUN,
    S_DRAIN,
    S_DUMP,
    S_DONE
  } run_state_e;

  function automatic int dump_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_port_mux.sv
// rtl/mem_port_mux.sv - selects CPU MEM-stage signals or the dump read address onto the data-memory port
module mem_port_mux
  import cpu_pkg::*;
#(
  parameter int IDX_W = 9
) (
  input  logic              dump_own,
  input  logic [IDX_W-1:0]  dump_index,
  input  logic [WORD_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata
);

  always_comb begin
    mem_addr  = cpu_addr;
    mem_we    = cpu_we;
    mem_wdata = cpu_wdata;
    if (dump_own) begin
      // Word index becomes a byte address; writes are blocked while the dump owns the port.
      mem_addr              = '0;
      mem_addr[IDX_W+1:2]   = dump_index;
      mem_we                = 1'b0;
      mem_wdata             = '0;
    end
  end

endmodule

// File: rtl/cpu_run_sequencer.sv
// rtl/cpu_run_sequencer.sv - reset/run/halt-drain/memory-dump controller for the 5-stage CPU
// Optional run-cycle limit is enabled by defining CYCLE_TIMEOUT_EN.
module cpu_run_sequencer
  import cpu_pkg::*;
#(
  parameter int                RESET_CYCLES = 2,
  parameter int                DRAIN_CYCLES = 3,
  parameter int                RAM_DEPTH    = 512,
  parameter logic [WORD_W-1:0] HALT_WORD    = HALT_WORD_DEF,
  parameter int                MAX_CYCLES   = 200,
  localparam int               IDX_W        = dump_idx_w(RAM_DEPTH)
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [WORD_W-1:0] Inst_D,
  input  logic [WORD_W-1:0] MemAddr_M,
  input  logic              MemWriteEN_M,
  input  logic [WORD_W-1:0] MemWriteData_M,
  input  logic [WORD_W-1:0] MemReadData,
  input  logic              Dump_Ready,
  output logic              CPU_RESET,
  output logic              CPU_HALT_F,
  output logic              CPU_STALL,
  output logic [WORD_W-1:0] Mem_Addr,
  output logic              Mem_WriteEN,
  output logic [WORD_W-1:0] Mem_WriteData,
  output logic              Dump_Valid,
  output logic [WORD_W-1:0] Dump_Data,
  output logic [IDX_W-1:0]  Dump_Index,
  output logic [WORD_W-1:0] CycleCount,
  output logic              Done,
  output logic              Timeout
);

  localparam logic [15:0]      RST_LAST   = 16'(RESET_CYCLES - 1);
  localparam logic [15:0]      DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(RAM_DEPTH - 1);

  run_state_e        state_q, state_d;
  logic [15:0]       phase_cnt_q, phase_cnt_d;
  logic [WORD_W-1:0] cycle_count_q, cycle_count_d, cycle_inc;
  logic [IDX_W-1:0]  dump_index_q, dump_index_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              halt_f_q, halt_f_d;
  logic              stall_q, stall_d;
  logic              done_q, done_d;

`ifdef CYCLE_TIMEOUT_EN
  localparam logic [WORD_W-1:0] CYCLE_LIMIT = WORD_W'(MAX_CYCLES);
  logic timeout_q, timeout_d;
  assign Timeout = timeout_q;
`else
  logic unused_max_cycles;
  assign unused_max_cycles = ^(32'(MAX_CYCLES));
  assign Timeout = 1'b0;
`endif

  assign cycle_inc = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 32'd1;

  always_comb begin
    state_d       = state_q;
    phase_cnt_d   = phase_cnt_q;
    cycle_count_d = cycle_count_q;
    dump_index_d  = dump_index_q;
`ifdef CYCLE_TIMEOUT_EN
    timeout_d     = timeout_q;
`endif
    case (state_q)
      S_RST: begin
        if (phase_cnt_q == RST_LAST) begin
          state_d     = S_RUN;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        cycle_count_d = cycle_inc;
        // An X/Z instruction fails the compare and is not treated as HALT.
        if (Inst_D == HALT_WORD) begin
          state_d = S_DRAIN;
        end
`ifdef CYCLE_TIMEOUT_EN
        else if (cycle_count_q >= CYCLE_LIMIT) begin
          state_d   = S_DRAIN;
          timeout_d = 1'b1;
        end
`endif
      end
      S_DRAIN: begin
        cycle_count_d = cycle_inc;
        if (phase_cnt_q == DRAIN_LAST) begin
          state_d     = S_DUMP;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + 16'd1;
        end
      end
      S_DUMP: begin
        if (Dump_Ready) begin
          if (dump_index_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            dump_index_d = dump_index_q + 1'b1;
          end
        end
      end
      S_DONE: begin
      end
      default: state_d = S_RST;
    endcase

    cpu_reset_d = (state_d == S_RST);
    halt_f_d    = (state_d == S_DRAIN) || (state_d == S_DUMP) || (state_d == S_DONE);
    stall_d     = (state_d == S_DUMP) || (state_d == S_DONE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q       <= S_RST;
      phase_cnt_q   <= '0;
      cycle_count_q <= '0;
      dump_index_q  <= '0;
      cpu_reset_q   <= 1'b1;
      halt_f_q      <= 1'b0;
      stall_q       <= 1'b0;
      done_q        <= 1'b0;
`ifdef CYCLE_TIMEOUT_EN
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      phase_cnt_q   <= phase_cnt_d;
      cycle_count_q <= cycle_count_d;
      dump_index_q  <= dump_index_d;
      cpu_reset_q   <= cpu_reset_d;
      halt_f_q      <= halt_f_d;
      stall_q       <= stall_d;
      done_q        <= done_d;
`ifdef CYCLE_TIMEOUT_EN
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign CPU_RESET  = cpu_reset_q;
  assign CPU_HALT_F = halt_f_q;
  assign CPU_STALL  = stall_q;
  assign Done       = done_q;
  assign CycleCount = cycle_count_q;
  assign Dump_Index = dump_index_q;
  assign Dump_Valid = (state_q == S_DUMP);
  assign Dump_Data  = MemReadData;

  mem_port_mux #(
    .IDX_W(IDX_W)
  ) u_mem_port_mux (
    .dump_own   ((state_q == S_DUMP) || (state_q == S_DONE)),
    .dump_index (dump_index_q),
    .cpu_addr   (MemAddr_M),
    .cpu_we     (MemWriteEN_M),
    .cpu_wdata  (MemWriteData_M),
    .mem_addr   (Mem_Addr),
    .mem_we     (Mem_WriteEN),
    .mem_wdata  (Mem_WriteData)
  );

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// tb/tb_cpu_run_sequencer.sv - directed table-driven bench for cpu_run_sequencer with a data-RAM model
module tb_cpu_run_sequencer;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [31:0] Inst_D, MemAddr_M, MemWriteData_M, MemReadData;
  logic        MemWriteEN_M, Dump_Ready;
  logic        CPU_RESET, CPU_HALT_F, CPU_STALL, Mem_WriteEN, Dump_Valid, Done, Timeout;
  logic [31:0] Mem_Addr, Mem_WriteData, Dump_Data, CycleCount;
  logic [8:0]  Dump_Index;

  logic [31:0] ram [512];
  int checks = 0;
  int errors = 0;

  always #5 CLOCK = ~CLOCK;

  assign MemReadData = ram[Mem_Addr[10:2]];
  always @(posedge CLOCK) if (Mem_WriteEN) ram[Mem_Addr[10:2]] <= Mem_WriteData;

  cpu_run_sequencer dut (
    .CLOCK(CLOCK), .RESET(RESET), .Inst_D(Inst_D), .MemAddr_M(MemAddr_M),
    .MemWriteEN_M(MemWriteEN_M), .MemWriteData_M(MemWriteData_M), .MemReadData(MemReadData),
    .Dump_Ready(Dump_Ready), .CPU_RESET(CPU_RESET), .CPU_HALT_F(CPU_HALT_F), .CPU_STALL(CPU_STALL),
    .Mem_Addr(Mem_Addr), .Mem_WriteEN(Mem_WriteEN), .Mem_WriteData(Mem_WriteData),
    .Dump_Valid(Dump_Valid), .Dump_Data(Dump_Data), .Dump_Index(Dump_Index),
    .CycleCount(CycleCount), .Done(Done), .Timeout(Timeout)
  );

  typedef struct {
    logic        rst;
    logic [31:0] inst;
    logic        cr, hf, st, dv;
    logic [31:0] cc;
    logic [8:0]  idx;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, input logic [31:0] inst, input logic cr, input logic hf,
                              input logic st, input logic dv, input logic [31:0] cc, input logic [8:0] idx);
    vec_t v;
    v.rst = rst; v.inst = inst; v.cr = cr; v.hf = hf; v.st = st; v.dv = dv; v.cc = cc; v.idx = idx;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_release();
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    logic rdy;
    for (int k = 0; k < 512; k++) ram[k] = 32'(k * 3);
    RESET = 1'b1; Inst_D = '0; MemAddr_M = '0; MemWriteEN_M = 1'b0;
    MemWriteData_M = '0; Dump_Ready = 1'b0;

    // Reset held, two-cycle countdown (HALT on its last cycle ignored), run, HALT at run cycle 10, drain.
    for (int i = 0; i < 3; i++) vecs[i] = mk(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 9'd0);
    vecs[3] = mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 9'd0);
    vecs[4] = mk(1'b0, HALT,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 9'd0);
    for (int k = 0; k < 10; k++)
      vecs[5+k] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'(k + 1), 9'd0);
    vecs[15] = mk(1'b0, HALT,  1'b0, 1'b1, 1'b0, 1'b0, 32'd11, 9'd0);
    vecs[16] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd12, 9'd0);
    vecs[17] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd13, 9'd0);
    vecs[18] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd14, 9'd0);

    for (int i = 0; i < NV; i++) begin
      RESET = vecs[i].rst;
      Inst_D = vecs[i].inst;
      tick();
      chk_b($sformatf("v%0d_cpu_reset", i), CPU_RESET, vecs[i].cr);
      chk_b($sformatf("v%0d_halt_f", i), CPU_HALT_F, vecs[i].hf);
      chk_b($sformatf("v%0d_stall", i), CPU_STALL, vecs[i].st);
      chk_b($sformatf("v%0d_dump_valid", i), Dump_Valid, vecs[i].dv);
      chk_w($sformatf("v%0d_cycle_count", i), CycleCount, vecs[i].cc);
      chk_w($sformatf("v%0d_dump_index", i), 32'(Dump_Index), 32'(vecs[i].idx));
      chk_b($sformatf("v%0d_done", i), Done, 1'b0);
      chk_b($sformatf("v%0d_timeout", i), Timeout, 1'b0);
    end

    // Full dump with alternating Ready while the CPU side keeps trying to write.
    hs = 0;
    rdy = 1'b1;
    for (int t = 0; t < 2000 && !Done; t++) begin
      Dump_Ready = rdy;
      MemWriteEN_M = 1'b1;
      MemAddr_M = 32'(t * 4);
      MemWriteData_M = 32'hBAD0_0000 | 32'(t);
      #1;
      chk_b("dump_valid", Dump_Valid, 1'b1);
      chk_w("dump_index", 32'(Dump_Index), 32'(hs));
      chk_w("dump_data", Dump_Data, 32'(hs * 3));
      chk_b("dump_mem_we", Mem_WriteEN, 1'b0);
      tick();
      if (rdy) hs++;
      rdy = ~rdy;
    end
    chk_w("dump_handshakes", 32'(hs), 32'd512);
    chk_b("done_after_dump", Done, 1'b1);
    chk_b("valid_after_dump", Dump_Valid, 1'b0);
    chk_w("index_no_wrap", 32'(Dump_Index), 32'd511);
    chk_b("stall_in_done", CPU_STALL, 1'b1);
    chk_b("halt_f_in_done", CPU_HALT_F, 1'b1);
    chk_b("mem_we_in_done", Mem_WriteEN, 1'b0);
    chk_w("cycle_count_frozen", CycleCount, 32'd14);
    Inst_D = HALT;
    repeat (5) tick();
    chk_b("done_sticky", Done, 1'b1);
    chk_w("index_sticky", 32'(Dump_Index), 32'd511);

    // Passthrough in S_RUN, then reset in the middle of a dump.
    Inst_D = '0; MemWriteEN_M = 1'b0; Dump_Ready = 1'b0;
    reset_release();
    chk_b("run_cpu_reset", CPU_RESET, 1'b0);
    chk_w("run_cycle_start", CycleCount, 32'd0);
    MemAddr_M = 32'h40; MemWriteEN_M = 1'b1; MemWriteData_M = 32'hDEAD_BEEF;
    #1;
    chk_w("pass_addr", Mem_Addr, 32'h40);
    chk_b("pass_we", Mem_WriteEN, 1'b1);
    chk_w("pass_wdata", Mem_WriteData, 32'hDEAD_BEEF);
    MemWriteEN_M = 1'b0;
    tick();
    Inst_D = HALT;
    tick();
    Inst_D = '0;
    for (int t = 0; t < 10 && !Dump_Valid; t++) tick();
    chk_b("reach_dump", Dump_Valid, 1'b1);
    Dump_Ready = 1'b1;
    for (int t = 0; t < 200 && Dump_Index != 9'd100; t++) tick();
    chk_w("mid_dump_index", 32'(Dump_Index), 32'd100);
    chk_w("mid_dump_data", Dump_Data, 32'd300);
    RESET = 1'b1;
    tick();
    chk_b("rst_mid_valid", Dump_Valid, 1'b0);
    chk_w("rst_mid_index", 32'(Dump_Index), 32'd0);
    chk_b("rst_mid_done", Done, 1'b0);
    chk_b("rst_mid_cpu_reset", CPU_RESET, 1'b1);
    chk_b("rst_mid_halt_f", CPU_HALT_F, 1'b0);
    chk_b("rst_mid_stall", CPU_STALL, 1'b0);
    chk_w("rst_mid_cycle", CycleCount, 32'd0);

    // Long run with no HALT: cycle limit only when the option is built in.
    Dump_Ready = 1'b0;
    reset_release();
`ifdef CYCLE_TIMEOUT_EN
    repeat (201) tick();
    chk_b("limit_timeout", Timeout, 1'b1);
    chk_b("limit_halt_f", CPU_HALT_F, 1'b1);
    chk_w("limit_cycle", CycleCount, 32'd201);
    for (int t = 0; t < 10 && !Dump_Valid; t++) tick();
    chk_b("limit_dump", Dump_Valid, 1'b1);
    reset_release();
    repeat (200) tick();
    Inst_D = HALT;
    tick();
    Inst_D = '0;
    chk_b("limit_halt_wins_timeout", Timeout, 1'b0);
    chk_b("limit_halt_wins_halt_f", CPU_HALT_F, 1'b1);
    chk_w("limit_halt_wins_cycle", CycleCount, 32'd201);
`else
    repeat (260) tick();
    chk_b("nolimit_timeout", Timeout, 1'b0);
    chk_b("nolimit_halt_f", CPU_HALT_F, 1'b0);
    chk_w("nolimit_cycle", CycleCount, 32'd260);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
